message_scroll_ctrl: RTL and testbench
======================================

MESSAGE_SCROLL_CTRL -- requirements
Module: message_scroll_ctrl

Interface
REQ-001 SHALL have parameter MSG_LEN, default 16, message depth in entries; power of two, at most 16.
REQ-002 SHALL have parameter REFRESH_DIV, default 25000, clk cycles per digit slot.
REQ-003 SHALL have parameter SCROLL_PERIOD, default 50000000, clk cycles per auto-scroll tick.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port step_pulse, input, 1, one-cycle debounced button pulse requesting a one-entry advance.
REQ-007 SHALL have port mode_pulse, input, 1, one-cycle pulse toggling PAUSE/RUN.
REQ-008 SHALL have port an, output, 4, active-low one-hot anode enables; bit 3 is the leftmost digit.
REQ-009 SHALL have port char_addr, output, 4, message address for the currently enabled digit.
REQ-010 SHALL have port pointer, output, 4, index of the leftmost displayed entry.
REQ-011 SHALL have port running, output, 1, high in RUN.
REQ-012 SHALL have port step_ack, output, 1, one-cycle pulse when an advance commits.

Function
REQ-013 SHALL count slot_cnt 0..REFRESH_DIV-1; at terminal count, digit advances 0,1,2,3,0 (wrap).
REQ-014 SHALL drive an = ~(4'b1000 >> digit): digit 0 gives 0111, digit 3 gives 1110.
REQ-015 SHALL drive char_addr = (pointer + digit) mod MSG_LEN, combinational from registered pointer/digit.
REQ-016 SHALL use a two-state FSM: PAUSE -> RUN on mode_pulse; RUN -> PAUSE on mode_pulse; otherwise hold.
REQ-017 SHALL, in RUN, count scroll_cnt 0..SCROLL_PERIOD-1 and raise an auto tick at terminal count; scroll_cnt is held at 0 in PAUSE and cleared on every FSM transition.
REQ-018 SHALL set the single pending flag on a step_pulse in either state or on an auto tick; a request that arrives while the flag is set is dropped.
REQ-019 SHALL restart scroll_cnt at 0 when a step_pulse arrives in RUN.
REQ-020 SHALL commit a pending advance only at the frame boundary (slot terminal with digit==3): pointer <= (pointer+1) mod MSG_LEN; clear pending; assert step_ack for that cycle.
REQ-021 SHALL make a request in the same cycle as a frame boundary commit in that cycle (pending is bypassed).
REQ-022 SHALL commit a step_pulse and an auto tick in the same cycle as one advance.
REQ-023 SHALL apply both effects when step_pulse and mode_pulse coincide: the state toggles and the step is requested.
REQ-024 SHALL wrap pointer from MSG_LEN-1 to 0.

Reset
REQ-025 SHALL, while reset is high at a clk edge, set: state PAUSE, pointer 0, digit 0 (an=0111), char_addr 0, slot_cnt 0, scroll_cnt 0, pending 0, running 0, step_ack 0.
REQ-026 SHALL give reset priority over all inputs; an uncommitted pending advance is discarded.

Configuration
REQ-027 SHALL, with macro SCROLL_CTRL_AUTO_EN defined, include the RUN state, scroll_cnt, and mode_pulse handling.
REQ-028 SHALL, without SCROLL_CTRL_AUTO_EN, leave no scroll_cnt; running is tied to 0, mode_pulse is ignored, and the pointer advances only on step_pulse.

Structure
REQ-029 SHALL take the state enum (PAUSE, RUN), the digit count constant (4) and the one-hot anode table from shared package scroll_ctrl_pkg.
REQ-030 SHALL implement slot_cnt and the digit counter in a sub-module digit_scan (outputs digit and frame_end).

Verification (REFRESH_DIV=2, SCROLL_PERIOD=40, MSG_LEN=16)
REQ-031 SHALL check: reset for 2 cycles -> an=0111, pointer=0, running=0; then an sequence 0111,1011,1101,1110, each held 2 cycles; char_addr 0,1,2,3.
REQ-032 SHALL check: PAUSE, step_pulse at cycle 3 -> step_ack at the first frame end (cycle 7); pointer=1; char_addr 1..4 in the next frame.
REQ-033 SHALL check: 3 step_pulses within one frame -> one step_ack; pointer advances by 1 only.
REQ-034 SHALL check: mode_pulse -> running=1; pointer advances once per 40 cycles, committed at the next frame end; after 16 advances pointer wraps to 0.
REQ-035 SHALL check: step_pulse and auto tick in the same cycle -> one advance; step_pulse and mode_pulse together -> state toggles and pointer +1.
REQ-036 SHALL check: reset while pending=1 -> no step_ack; pointer=0; state PAUSE.

Source files
------------

// File: rtl/scroll_ctrl_pkg.sv
// Shared types and constants for the scrolling message display controller.
// The RUN state is only used when SCROLL_CTRL_AUTO_EN is defined.
package scroll_ctrl_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 4;

    // Active-low anode enables indexed by digit; digit 0 is the leftmost (an[3]).
    localparam logic [NUM_DIGITS-1:0][3:0] AN_TABLE = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

endpackage

// File: rtl/message_scroll_ctrl_digit_scan.sv
// Display refresh scanner: holds each digit for REFRESH_DIV cycles, cycling 0..3.
// frame_end is high in the last cycle of digit 3, marking where the pointer may move.
module digit_scan
    import scroll_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 25000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] digit,
    output logic       frame_end
);

    localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic          slot_term;

    always_comb begin
        slot_term  = (slot_cnt_q == SW'(REFRESH_DIV - 1));
        slot_cnt_d = slot_term ? '0 : slot_cnt_q + 1'b1;
        digit_d    = slot_term ? digit_q + 1'b1 : digit_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q <= '0;
            digit_q    <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            digit_q    <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign frame_end = slot_term && (digit_q == 2'(NUM_DIGITS - 1));

endmodule

// File: rtl/message_scroll_ctrl.sv
// Scrolls a MSG_LEN-entry message across a 4-digit multiplexed display; advances commit at frame ends.
// Define SCROLL_CTRL_AUTO_EN to add the PAUSE/RUN auto-scroll timer driven by mode_pulse.
module message_scroll_ctrl
    import scroll_ctrl_pkg::*;
#(
    parameter int MSG_LEN       = 16,
    parameter int REFRESH_DIV   = 25000,
    parameter int SCROLL_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_pulse,
    input  logic       mode_pulse,
    output logic [3:0] an,
    output logic [3:0] char_addr,
    output logic [3:0] pointer,
    output logic       running,
    output logic       step_ack
);

    localparam logic [3:0] ADDR_MASK = 4'(MSG_LEN - 1);

    logic [1:0] digit;
    logic       frame_end;
    logic [3:0] pointer_q, pointer_d;
    logic       pending_q, pending_d;
    logic       auto_tick;
    logic       req;
    logic       commit;

    digit_scan #(.REFRESH_DIV(REFRESH_DIV)) u_digit_scan (
        .clk       (clk),
        .reset     (reset),
        .digit     (digit),
        .frame_end (frame_end)
    );

`ifdef SCROLL_CTRL_AUTO_EN
    localparam int SCW = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;

    state_e         state_q, state_d;
    logic [SCW-1:0] scroll_cnt_q, scroll_cnt_d;

    always_comb begin
        state_d      = state_q;
        scroll_cnt_d = '0;
        auto_tick    = (state_q == RUN) && (scroll_cnt_q == SCW'(SCROLL_PERIOD - 1));
        if (mode_pulse) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
        end else if (state_q == RUN && !step_pulse && !auto_tick) begin
            scroll_cnt_d = scroll_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PAUSE;
            scroll_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            scroll_cnt_q <= scroll_cnt_d;
        end
    end

    assign running = (state_q == RUN);
`else
    logic unused_mode_pulse;

    assign unused_mode_pulse = mode_pulse;
    assign auto_tick         = 1'b0;
    assign running           = 1'b0;
`endif

    // A request landing on the frame boundary commits immediately rather than waiting a frame.
    always_comb begin
        req       = step_pulse | auto_tick;
        commit    = frame_end & (pending_q | req);
        pointer_d = pointer_q;
        pending_d = pending_q | req;
        if (commit) begin
            pointer_d = (pointer_q + 4'd1) & ADDR_MASK;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pointer_q <= '0;
            pending_q <= 1'b0;
        end else begin
            pointer_q <= pointer_d;
            pending_q <= pending_d;
        end
    end

    assign an        = AN_TABLE[digit];
    assign char_addr = (pointer_q + {2'b00, digit}) & ADDR_MASK;
    assign pointer   = pointer_q;
    assign step_ack  = commit & ~reset;

endmodule

// File: tb/tb_message_scroll_ctrl.sv
// Randomized and directed bench with a cycle-level reference model and a decoupled scoreboard.
module tb_message_scroll_ctrl;

    localparam int MSG_LEN = 16;
    localparam int RD      = 2;
    localparam int SP      = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       step_pulse = 1'b0;
    logic       mode_pulse = 1'b0;
    logic [3:0] an;
    logic [3:0] char_addr;
    logic [3:0] pointer;
    logic       running;
    logic       step_ack;

    message_scroll_ctrl #(
        .MSG_LEN       (MSG_LEN),
        .REFRESH_DIV   (RD),
        .SCROLL_PERIOD (SP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_pulse (step_pulse),
        .mode_pulse (mode_pulse),
        .an         (an),
        .char_addr  (char_addr),
        .pointer    (pointer),
        .running    (running),
        .step_ack   (step_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] ca;
        logic [3:0] ptr;
        logic       run;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   mon_cyc  = 0;
    int   ack_seen = 0;

    // Reference model state: cycles since reset drive the scan position,
    // cycles since the last scroll restart drive the auto tick.
    int m_ptr  = 0;
    int m_t    = 0;
    int m_pend = 0;
    int m_run  = 0;
    int m_age  = 0;

    function automatic bit model_tick();
        return (m_run != 0) && ((m_age % SP) == SP - 1);
    endfunction

    task automatic check_true(input bit cond, input string what);
        checks++;
        if (!cond) begin
            failures++;
            $display("FAIL %s", what);
        end
    endtask

    task automatic cycle(input bit st, input bit md, input bit rs, input bit chk);
        exp_t e;
        int   dig;
        bit   fe;
        bit   req;
        bit   commit;
        @(posedge clk);
        #1;
        step_pulse = st;
        mode_pulse = md;
        reset      = rs;
        dig    = (m_t / RD) % 4;
        fe     = (m_t % (4 * RD)) == (4 * RD - 1);
        req    = st || model_tick();
        commit = !rs && fe && ((m_pend != 0) || req);
        e.an          = 4'b1111;
        e.an[3 - dig] = 1'b0;
        e.ca          = 4'((m_ptr + dig) % MSG_LEN);
        e.ptr         = 4'(m_ptr);
        e.run         = (m_run != 0);
        e.ack         = commit;
        if (chk) exp_q.push_back(e);
        if (rs) begin
            m_ptr  = 0;
            m_t    = 0;
            m_pend = 0;
            m_run  = 0;
            m_age  = 0;
        end else begin
            if (commit) begin
                m_ptr  = (m_ptr + 1) % MSG_LEN;
                m_pend = 0;
            end else if (req) begin
                m_pend = 1;
            end
`ifdef SCROLL_CTRL_AUTO_EN
            if (md) begin
                m_run = (m_run != 0) ? 0 : 1;
                m_age = 0;
            end else if (m_run != 0) begin
                m_age = st ? 0 : m_age + 1;
            end else begin
                m_age = 0;
            end
`endif
            m_t++;
        end
    endtask

    always @(negedge clk) begin
        if (step_ack === 1'b1) ack_seen++;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({an, char_addr, pointer, running, step_ack} !== mon_e) begin
                failures++;
                $display("FAIL cycle_%0d an=%b/%b char_addr=%0d/%0d pointer=%0d/%0d running=%b/%b step_ack=%b/%b (actual/required)",
                         mon_cyc, an, mon_e.an, char_addr, mon_e.ca, pointer, mon_e.ptr,
                         running, mon_e.run, step_ack, mon_e.ack);
            end
        end
        mon_cyc++;
    end

    initial begin
        // Reset for two cycles; outputs are only defined after the first reset edge.
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check_true(an === 4'b0111 && pointer === 4'd0 && running === 1'b0,
                   "reset state: an/pointer/running not at reset values");

        // Scan order, then a step at cycle 3 committing at the frame end (cycle 7).
        ack_seen = 0;
        for (int i = 0; i < 16; i++) cycle(i == 3, 1'b0, 1'b0, 1'b1);
        check_true(ack_seen == 1, "timeout: expected exactly one step_ack after step_pulse");

        // Three steps inside one frame collapse to a single advance.
        ack_seen = 0;
        for (int i = 0; i < 16; i++) cycle(i == 1 || i == 3 || i == 5, 1'b0, 1'b0, 1'b1);
        check_true(ack_seen == 1, "timeout: expected exactly one step_ack for three steps in one frame");

        // Step landing exactly on the frame boundary commits in that cycle.
        for (int i = 0; i < 16; i++) cycle(i == 7, 1'b0, 1'b0, 1'b1);

        // Enter RUN and scroll long enough to wrap the pointer.
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 17 * SP + 40; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Step coinciding with an auto tick.
        for (int n = 0; n < SP + 2 && !model_tick(); n++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Step and mode together: state toggles and the step still advances.
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset while an advance is pending, from PAUSE and then from RUN.
        for (int n = 0; n < 8 && (m_t % 8) != 0; n++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                  $urandom_range(0, 299) == 0, 1'b1);
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
